// File: rtl/mic1_io_pkg.sv
// Shared definitions for the mic1 memory-mapped IO blocks.
//   IO_DATA_ADDR / IO_STATUS_ADDR : default IO register addresses
//   uart_tx_state_t               : serial transmitter frame states
//   STAT_*                        : bit positions inside the status word
package mic1_io_pkg;

    localparam logic [31:0] IO_DATA_ADDR   = 32'hFFFF_FFFD;
    localparam logic [31:0] IO_STATUS_ADDR = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

    localparam int STAT_BUSY = 0;
    localparam int STAT_FULL = 1;
    localparam int STAT_OVF  = 2;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with first-word fall-through: the head entry is
// always visible on o_rdata while o_empty is low.
//   clk, resetn      : clock, asynchronous active-low reset (empties the FIFO)
//   i_push, i_wdata  : write request and data
//   i_pop            : consume the head entry
//   o_rdata          : head entry, read straight from the storage flops
//   o_full, o_empty  : occupancy flags
//   o_count          : number of stored entries (0..DEPTH)
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    assign w_do_pop  = i_pop && !o_empty;
    // When full, the slot being vacated by the pop is the one we write into.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Storage carries no reset: stale contents are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mic1_uart_tx_port.sv
// Memory-mapped 8N1 serial transmitter for the mic1 data-memory port.
//   clk, resetn  : clock, asynchronous active-low reset
//   mem_addr     : CPU data address
//   mem_write    : CPU write strobe; a write to IO_DATA_ADDR queues mem_wdata[7:0]
//   mem_wdata    : CPU write data (only [7:0] used)
//   mem_read     : CPU read strobe
//   rdata        : status word {29'b0, overflow, fifo_full, tx_busy}
//   hit          : mem_read && mem_addr == IO_STATUS_ADDR (combinational)
//   tx           : serial line, idle high, LSB first, driven from a flop
//   busy         : FIFO non-empty or frame in flight (registered)
module mic1_uart_tx_port #(
    parameter int unsigned CLKS_PER_BIT   = 868,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter logic [31:0] IO_DATA_ADDR   = mic1_io_pkg::IO_DATA_ADDR,
    parameter logic [31:0] IO_STATUS_ADDR = mic1_io_pkg::IO_STATUS_ADDR
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] mem_addr,
    input  logic        mem_write,
    input  logic [31:0] mem_wdata,
    input  logic        mem_read,
    output logic [31:0] rdata,
    output logic        hit,
    output logic        tx,
    output logic        busy
);

    import mic1_io_pkg::*;

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    // Write strobe edge detection
    logic w_wr_qual;
    logic r_wr_qual;
    logic w_push_req;

    // FIFO interface
    logic             w_pop;
    logic [7:0]       w_fifo_head;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [CNT_W-1:0] w_fifo_count;

    // Transmitter state
    uart_tx_state_t    r_state;
    uart_tx_state_t    w_state_next;
    logic [BAUD_W-1:0] r_baud;
    logic [BAUD_W-1:0] w_baud_next;
    logic [2:0]        r_bit;
    logic [2:0]        w_bit_next;
    logic [7:0]        r_shift;
    logic [7:0]        w_shift_next;
    logic              w_baud_done;
    logic              r_tx;
    logic              w_tx_next;
    logic              r_busy;
    logic              r_ovf;
    logic              w_ovf_event;

    logic w_unused_wdata;
    assign w_unused_wdata = &{1'b0, mem_wdata[31:8]};

    // A held strobe must queue exactly one byte, so only its first cycle counts.
    assign w_wr_qual  = mem_write && (mem_addr == IO_DATA_ADDR);
    assign w_push_req = w_wr_qual && !r_wr_qual;

    assign hit = mem_read && (mem_addr == IO_STATUS_ADDR);

    // Dropped only if the FIFO cannot make room this cycle.
    assign w_ovf_event = w_push_req && w_fifo_full && !w_pop;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (w_push_req),
        .i_wdata (mem_wdata[7:0]),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign w_baud_done = (r_baud == BAUD_LAST);

    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_fifo_head;
                    w_baud_next  = '0;
                    w_bit_next   = '0;
                    w_state_next = START;
                end
            end
            START: begin
                if (w_baud_done) begin
                    w_baud_next  = '0;
                    w_state_next = DATA;
                end else begin
                    w_baud_next = r_baud + BAUD_W'(1);
                end
            end
            DATA: begin
                if (w_baud_done) begin
                    w_baud_next  = '0;
                    w_shift_next = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        w_state_next = STOP;
                    end else begin
                        w_bit_next = r_bit + 3'd1;
                    end
                end else begin
                    w_baud_next = r_baud + BAUD_W'(1);
                end
            end
            STOP: begin
                if (w_baud_done) begin
                    w_baud_next  = '0;
                    w_state_next = IDLE;
                end else begin
                    w_baud_next = r_baud + BAUD_W'(1);
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // The line level follows the current state, so tx trails the state
    // register by one cycle and never sees a combinational input path.
    always_comb begin
        w_tx_next = 1'b1;
        if (r_state == START) begin
            w_tx_next = 1'b0;
        end else if (r_state == DATA) begin
            w_tx_next = r_shift[0];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_qual <= 1'b0;
            r_state   <= IDLE;
            r_baud    <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_wr_qual <= w_wr_qual;
            r_state   <= w_state_next;
            r_baud    <= w_baud_next;
            r_bit     <= w_bit_next;
            r_shift   <= w_shift_next;
            r_tx      <= w_tx_next;
            r_busy    <= (w_fifo_count != '0) || (r_state != IDLE);
            // A fresh overflow beats the clear-on-read in the same cycle.
            if (w_ovf_event) begin
                r_ovf <= 1'b1;
            end else if (hit) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_comb begin
        rdata            = '0;
        rdata[STAT_BUSY] = (r_state != IDLE);
        rdata[STAT_FULL] = w_fifo_full;
        rdata[STAT_OVF]  = r_ovf;
    end

    assign tx   = r_tx;
    assign busy = r_busy;

endmodule

// File: tb/tb_mic1_uart_tx_port.sv
// Bench for mic1_uart_tx_port with CLKS_PER_BIT = 4, FIFO_DEPTH = 4.
// Each scenario is a timed list of bus operations; the expected line,
// busy and status values come from a frame-schedule model: every accepted
// byte gets a pop time, and the waveform is built from those times.
module tb_mic1_uart_tx_port;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;
    localparam int MAXE  = 1024;
    localparam logic [31:0] A_DATA = 32'hFFFF_FFFD;
    localparam logic [31:0] A_STAT = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] mem_addr = '0;
    logic        mem_write = 1'b0;
    logic [31:0] mem_wdata = '0;
    logic        mem_read = 1'b0;
    logic [31:0] rdata;
    logic        hit;
    logic        tx;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mic1_uart_tx_port #(
        .CLKS_PER_BIT   (CPB),
        .FIFO_DEPTH     (DEPTH),
        .IO_DATA_ADDR   (A_DATA),
        .IO_STATUS_ADDR (A_STAT)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .mem_addr  (mem_addr),
        .mem_write (mem_write),
        .mem_wdata (mem_wdata),
        .mem_read  (mem_read),
        .rdata     (rdata),
        .hit       (hit),
        .tx        (tx),
        .busy      (busy)
    );

    typedef struct {
        int          t;
        bit          is_read;
        logic [31:0] addr;
        logic [31:0] wd;
        int          len;
    } op_t;

    op_t        ops[$];
    int         acc_p[$];   // edge at which an accepted byte is pushed
    int         acc_pop[$]; // edge at which it is popped into the shifter
    logic [7:0] acc_d[$];
    int         drop_e[$];  // edges at which a byte was dropped
    int         rd_t[$];    // cycles with a status read
    logic       tx_w[0:MAXE];
    logic       busy_w[0:MAXE];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_op(input int t, input bit rd, input logic [31:0] addr,
                          input logic [31:0] wd, input int len);
        op_t o;
        o.t = t; o.is_read = rd; o.addr = addr; o.wd = wd; o.len = len;
        ops.push_back(o);
    endtask

    // A byte pushed at edge p is popped once it is present and the previous
    // frame (40 cycles) plus one idle cycle have elapsed.
    task automatic build_model();
        int p, cnt, pop_now, pp;
        acc_p.delete(); acc_pop.delete(); acc_d.delete(); drop_e.delete(); rd_t.delete();
        foreach (ops[i]) begin
            if (ops[i].is_read) begin
                if (ops[i].addr == A_STAT) rd_t.push_back(ops[i].t);
            end else if (ops[i].addr == A_DATA) begin
                p = ops[i].t + 1;
                cnt = 0; pop_now = 0;
                foreach (acc_p[j]) begin
                    if (acc_p[j] < p && acc_pop[j] >= p) cnt++;
                    if (acc_pop[j] == p) pop_now = 1;
                end
                if (cnt == DEPTH && !pop_now) begin
                    drop_e.push_back(p);
                end else begin
                    pp = p + 1;
                    if (acc_pop.size() > 0 && acc_pop[$] + FRAME + 1 > pp) pp = acc_pop[$] + FRAME + 1;
                    acc_p.push_back(p);
                    acc_pop.push_back(pp);
                    acc_d.push_back(ops[i].wd[7:0]);
                end
            end
        end
    endtask

    function automatic logic exp_tx(input int e);
        int b;
        foreach (acc_pop[i]) begin
            if (e >= acc_pop[i] + 1 && e <= acc_pop[i] + FRAME) begin
                b = (e - acc_pop[i] - 1) / CPB;
                if (b == 0) return 1'b0;
                if (b == 9) return 1'b1;
                return acc_d[i][b-1];
            end
        end
        return 1'b1;
    endfunction

    function automatic logic exp_busy(input int e);
        foreach (acc_p[i]) begin
            if (e >= acc_p[i] + 1 && e <= acc_pop[i] + FRAME) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Status as held after edge t.
    function automatic logic [31:0] exp_status(input int t);
        logic [31:0] s;
        int c;
        bit cleared;
        s = '0; c = 0;
        foreach (acc_pop[i]) begin
            if (t >= acc_pop[i] && t <= acc_pop[i] + FRAME - 1) s[0] = 1'b1;
            if (acc_p[i] <= t && t < acc_pop[i]) c++;
        end
        if (c == DEPTH) s[1] = 1'b1;
        foreach (drop_e[i]) begin
            if (drop_e[i] <= t) begin
                cleared = 0;
                foreach (rd_t[j]) if (rd_t[j] >= drop_e[i] && rd_t[j] <= t - 1) cleared = 1;
                if (!cleared) s[2] = 1'b1;
            end
        end
        return s;
    endfunction

    task automatic run_scenario(input string name, input int n);
        int bad_tx, bad_busy, idx;
        build_model();
        foreach (ops[i]) begin
            if (ops[i].is_read)
                $display("[%s] t=%0d read  addr=%h", name, ops[i].t, ops[i].addr);
            else
                $display("[%s] t=%0d write addr=%h data=%h len=%0d", name, ops[i].t,
                         ops[i].addr, ops[i].wd, ops[i].len);
        end
        for (int t = 0; t < n; t++) begin
            mem_write = 1'b0; mem_read = 1'b0; mem_addr = '0; mem_wdata = '0;
            foreach (ops[i]) begin
                if (!ops[i].is_read && t >= ops[i].t && t < ops[i].t + ops[i].len) begin
                    mem_write = 1'b1; mem_addr = ops[i].addr; mem_wdata = ops[i].wd;
                end
                if (ops[i].is_read && t == ops[i].t) begin
                    mem_read = 1'b1; mem_addr = ops[i].addr;
                end
            end
            if (mem_read || mem_write) begin
                #1;
                check($sformatf("%s hit t=%0d", name, t), 32'(hit),
                      32'(mem_read && mem_addr == A_STAT));
                if (mem_read && mem_addr == A_STAT)
                    check($sformatf("%s status t=%0d", name, t), rdata, exp_status(t));
            end
            tick();
            tx_w[t+1]   = tx;
            busy_w[t+1] = busy;
        end
        mem_write = 1'b0; mem_read = 1'b0; mem_addr = '0; mem_wdata = '0;
        bad_tx = 0; bad_busy = 0;
        for (int e = n; e >= 1; e--) begin
            if (tx_w[e] !== exp_tx(e)) bad_tx = e;
            if (busy_w[e] !== exp_busy(e)) bad_busy = e;
        end
        idx = (bad_tx != 0) ? bad_tx : n;
        check($sformatf("%s tx edge %0d", name, idx), 32'(tx_w[idx]), 32'(exp_tx(idx)));
        idx = (bad_busy != 0) ? bad_busy : n;
        check($sformatf("%s busy edge %0d", name, idx), 32'(busy_w[idx]), 32'(exp_busy(idx)));
        $display("[%s] done: %0d accepted, %0d dropped", name, acc_p.size(), drop_e.size());
    endtask

    initial begin
        int t, nw, mid, lows, bhigh;
        logic [31:0] rnd;

        // Reset state
        mem_addr = A_STAT;
        repeat (3) @(posedge clk);
        #1;
        check("reset tx", 32'(tx), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset rdata", rdata, 32'd0);
        check("reset hit", 32'(hit), 32'd0);
        #2 resetn = 1'b1;
        mem_addr = '0;
        tick();

        // Single byte
        ops.delete();
        add_op(0, 0, A_DATA, 32'h0000_0041, 1);
        run_scenario("single", 60);

        // Held strobe pushes one byte
        ops.delete();
        add_op(0, 0, A_DATA, 32'h1234_5655, 5);
        add_op(10, 1, A_STAT, '0, 1);
        run_scenario("held", 60);

        // Overflow: six writes two cycles apart
        ops.delete();
        for (int i = 0; i < 6; i++) add_op(2 * i, 0, A_DATA, 32'h30 + i, 1);
        add_op(42, 1, A_STAT, '0, 1);
        add_op(50, 1, A_STAT, '0, 1);
        add_op(220, 1, A_STAT, '0, 1);
        run_scenario("overflow", 230);

        // Back-to-back frames
        ops.delete();
        add_op(0, 0, A_DATA, 32'hA5, 1);
        add_op(2, 0, A_DATA, 32'h3C, 1);
        add_op(4, 0, A_DATA, 32'hFF, 1);
        run_scenario("b2b", 140);

        // Address decode
        ops.delete();
        add_op(0, 0, A_STAT, 32'h77, 1);
        add_op(5, 1, A_DATA, '0, 1);
        add_op(10, 1, A_STAT, '0, 1);
        run_scenario("decode", 60);

        // Randomized scenarios
        for (int s = 0; s < 6; s++) begin
            ops.delete();
            t = 0;
            nw = $urandom_range(1, 7);
            for (int i = 0; i < nw; i++) begin
                rnd = $urandom;
                add_op(t, 0, ($urandom_range(0, 7) == 0) ? A_STAT : A_DATA, rnd, $urandom_range(1, 3));
                t = t + ops[$].len + $urandom_range(1, 12);
            end
            mid = t + $urandom_range(0, 60);
            add_op(mid, 1, A_STAT, '0, 1);
            add_op(mid + 8 * (FRAME + 1), 1, A_STAT, '0, 1);
            run_scenario($sformatf("rand%0d", s), mid + 8 * (FRAME + 1) + 5);
        end

        // Reset during DATA bit 3 of 0xF0 (bit 3 is 0)
        mem_addr = A_DATA; mem_wdata = 32'hF0; mem_write = 1'b1;
        tick();
        mem_write = 1'b0; mem_addr = '0; mem_wdata = '0;
        repeat (18) tick();
        check("midframe tx before reset", 32'(tx), 32'd0);
        #2 resetn = 1'b0;
        #1;
        check("midframe tx async", 32'(tx), 32'd1);
        check("midframe busy async", 32'(busy), 32'd0);
        check("midframe rdata async", rdata, 32'd0);
        repeat (2) @(posedge clk);
        #3 resetn = 1'b1;
        lows = 0; bhigh = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (tx !== 1'b1) lows++;
            if (busy !== 1'b0) bhigh++;
        end
        $display("[reset] post-release: %0d low samples, %0d busy samples", lows, bhigh);
        check("post-reset tx low count", lows, 0);
        check("post-reset busy count", bhigh, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
